// File: rtl/video_port_pkg.sv
// Shared definitions for the native video input port: FSM encoding,
// parameter string constants and the frame marker bundle.
package video_port_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_ACTIVE,
        ST_PAD
    } port_state_t;

    localparam string MODE_LINE = "LINE";
    localparam string MODE_ONCE = "ONCE";
    localparam string FSYNC_ON  = "ON";
    localparam string FSYNC_OFF = "OFF";

    typedef struct packed {
        logic falign;
        logic lalign;
        logic ealign;
    } marker_t;

    localparam marker_t MARKER_NONE = '0;

endpackage

// File: rtl/pix_lane_packer.sv
// Collects pixels into NPIX lanes and emits a registered word when the top
// lane fills or the line is flushed; unfilled lanes carry PAD_VALUE.
module pix_lane_packer #(
    parameter int unsigned      DSIZE     = 24,
    parameter int unsigned      NPIX      = 2,
    parameter logic [DSIZE-1:0] PAD_VALUE = '0
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [DSIZE-1:0]       wr_data,
    input  logic                   flush,
    input  logic                   discard,
    output logic                   emit,
    output logic                   odata_vld,
    output logic [DSIZE*NPIX-1:0]  odata
);

    localparam int unsigned LW = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(NPIX - 1);
    localparam logic [NPIX-1:0][DSIZE-1:0] PAD_WORD = {NPIX{PAD_VALUE}};

    logic [LW-1:0]               lane;
    logic [LW-1:0]               lane_base;
    logic [NPIX-1:0][DSIZE-1:0]  lanes;
    logic [NPIX-1:0][DSIZE-1:0]  word_next;

    // A discard on the same cycle as a write starts the new word from lane 0.
    always_comb begin
        lane_base            = discard ? '0 : lane;
        word_next            = discard ? PAD_WORD : lanes;
        word_next[lane_base] = wr_data;
        emit                 = wr_en && (flush || lane_base == LAST_LANE);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            lane      <= '0;
            // NOTE: the lane registers are few, so they are reset to PAD and
            // a partial word can never carry stale pixels from before reset.
            lanes     <= PAD_WORD;
            odata_vld <= 1'b0;
            odata     <= '0;
        end else begin
            odata_vld <= emit;
            if (emit) begin
                odata <= word_next;
                lanes <= PAD_WORD;
                lane  <= '0;
            end else if (wr_en) begin
                lanes <= word_next;
                lane  <= lane_base + 1'b1;
            end else if (discard) begin
                lanes <= PAD_WORD;
                lane  <= '0;
            end
        end
    end

endmodule

// File: rtl/native_in_packer.sv
// Native video input port: vsync/de stream to NPIX-pixel words with every line
// forced to hactive pixels, frame markers and sticky length errors.
module native_in_packer
    import video_port_pkg::*;
#(
    parameter int unsigned      DSIZE      = 24,
    parameter int unsigned      NPIX       = 2,
    parameter string            MODE       = MODE_LINE,
    parameter string            FRAME_SYNC = FSYNC_OFF,
    parameter bit               VS_POL     = 1'b1,
    parameter logic [DSIZE-1:0] PAD_VALUE  = '0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic [15:0]           vactive,
    input  logic [15:0]           hactive,
    input  logic                  vsync,
    input  logic                  de,
    input  logic [DSIZE-1:0]      idata,
    input  logic                  fsync,
    input  logic                  err_clr,
    output logic                  falign,
    output logic                  lalign,
    output logic                  ealign,
    output logic                  odata_vld,
    output logic [DSIZE*NPIX-1:0] odata,
    output logic                  err_long,
    output logic                  err_short
);

    localparam bit LINE_MODE = (MODE != MODE_ONCE);
    localparam bit FS_ON     = (FRAME_SYNC == FSYNC_ON);

    port_state_t      state, state_n;
    logic             vs_d, vs_act, frame_start;
    logic [15:0]      h_lat, v_lat, eff_h, eff_v;
    logic [15:0]      pix_cnt, line_cnt, pix_base, line_base;
    logic             line_full, full_base, first_pend, first_base;
    logic             wr_en, pad_wr, line_end, last_line;
    logic             set_long, set_short;
    logic [DSIZE-1:0] wr_data;
    logic             emit;
    marker_t          mk_q;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_n   = state;
        wr_en     = 1'b0;
        pad_wr    = 1'b0;
        set_long  = 1'b0;
        set_short = 1'b0;

        vs_act      = (vsync == VS_POL);
        frame_start = vs_act && !vs_d;
        // A frame start resets the counting context on the same cycle, so a
        // coincident pixel is counted as pixel 0 of the new frame.
        eff_h       = frame_start ? hactive : h_lat;
        eff_v       = frame_start ? vactive : v_lat;
        pix_base    = frame_start ? 16'd0 : pix_cnt;
        line_base   = frame_start ? 16'd0 : line_cnt;
        full_base   = frame_start ? 1'b0 : line_full;
        first_base  = frame_start || first_pend;

        if (frame_start) begin
            set_short = (state == ST_ACTIVE) || (state == ST_PAD);
            if (hactive == 16'd0 || vactive == 16'd0) begin
                state_n = ST_IDLE;
            end else if (FS_ON) begin
                state_n = ST_ARM;
            end else begin
                state_n = ST_ACTIVE;
                wr_en   = de;
            end
        end else begin
            unique case (state)
                ST_IDLE: ;
                ST_ARM: begin
                    if (fsync) state_n = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (de) begin
                        if (line_full) set_long = 1'b1;
                        else           wr_en    = 1'b1;
                    end else if (pix_cnt != 16'd0) begin
                        state_n   = ST_PAD;
                        set_short = 1'b1;
                    end
                end
                ST_PAD: begin
                    wr_en     = 1'b1;
                    pad_wr    = 1'b1;
                    set_short = de;
                end
                default: state_n = ST_IDLE;
            endcase
        end

        line_end  = wr_en && (pix_base + 16'd1 == eff_h);
        last_line = (line_base == eff_v - 16'd1);
        if (line_end) begin
            if (last_line)   state_n = ST_IDLE;
            else if (pad_wr) state_n = ST_ACTIVE;
        end
        wr_data = pad_wr ? PAD_VALUE : idata;
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            vs_d       <= 1'b0;
            h_lat      <= '0;
            v_lat      <= '0;
            pix_cnt    <= '0;
            line_cnt   <= '0;
            line_full  <= 1'b0;
            first_pend <= 1'b0;
            mk_q       <= MARKER_NONE;
            err_long   <= 1'b0;
            err_short  <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every register reading the
            // pre-edge values of the others, independent of statement order.
            state <= state_n;
            vs_d  <= vs_act;
            h_lat <= eff_h;
            v_lat <= eff_v;
            if (line_end) begin
                pix_cnt  <= '0;
                line_cnt <= last_line ? 16'd0 : line_base + 16'd1;
            end else begin
                pix_cnt  <= wr_en ? pix_base + 16'd1 : pix_base;
                line_cnt <= line_base;
            end
            // A line completed by real pixels drops further de until it falls.
            if (line_end)  line_full <= !pad_wr;
            else if (!de)  line_full <= 1'b0;
            else           line_full <= full_base;
            first_pend  <= first_base && !emit;
            mk_q.falign <= emit && first_base;
            mk_q.lalign <= line_end && LINE_MODE;
            mk_q.ealign <= line_end && last_line;
            err_long    <= set_long  || (err_long  && !err_clr);
            err_short   <= set_short || (err_short && !err_clr);
        end
    end

    assign falign = mk_q.falign;
    assign lalign = mk_q.lalign;
    assign ealign = mk_q.ealign;

    pix_lane_packer #(
        .DSIZE     (DSIZE),
        .NPIX      (NPIX),
        .PAD_VALUE (PAD_VALUE)
    ) u_packer (
        .clock     (clock),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .flush     (line_end),
        .discard   (frame_start),
        .emit      (emit),
        .odata_vld (odata_vld),
        .odata     (odata)
    );

endmodule

// File: tb/tb_native_in_packer.sv
// Scoreboard bench for native_in_packer: a line-level model pushes expected
// words, monitors on the falling edge pop and compare.
module tb_native_in_packer;

    localparam int          DSIZE  = 24;
    localparam int          NPIX_A = 2;
    localparam int          NPIX_B = 3;
    localparam logic [23:0] PAD    = 24'hA5C3E1;

    typedef logic [127:0] word_t;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] hactive, vactive;
    logic        vsync_a, vsync_b, de, fsync, err_clr;
    logic [23:0] idata;

    logic        a_f, a_l, a_e, a_vld, a_elong, a_eshort;
    logic [47:0] a_odata;
    logic        b_f, b_l, b_e, b_vld, b_elong, b_eshort;
    logic [71:0] b_odata;

    word_t       exp_a[$];
    word_t       exp_b[$];
    logic [23:0] line_px[$];
    int          frame_lens[$];
    bit          exp_long, exp_short;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    native_in_packer #(
        .DSIZE(DSIZE), .NPIX(NPIX_A), .MODE("LINE"), .FRAME_SYNC("OFF"),
        .VS_POL(1'b1), .PAD_VALUE(PAD)
    ) dut_a (
        .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive),
        .vsync(vsync_a), .de(de), .idata(idata), .fsync(fsync), .err_clr(err_clr),
        .falign(a_f), .lalign(a_l), .ealign(a_e), .odata_vld(a_vld),
        .odata(a_odata), .err_long(a_elong), .err_short(a_eshort)
    );

    native_in_packer #(
        .DSIZE(DSIZE), .NPIX(NPIX_B), .MODE("LINE"), .FRAME_SYNC("ON"),
        .VS_POL(1'b1), .PAD_VALUE(PAD)
    ) dut_b (
        .clock(clock), .rst_n(rst_n), .vactive(vactive), .hactive(hactive),
        .vsync(vsync_b), .de(de), .idata(idata), .fsync(fsync), .err_clr(err_clr),
        .falign(b_f), .lalign(b_l), .ealign(b_e), .odata_vld(b_vld),
        .odata(b_odata), .err_long(b_elong), .err_short(b_eshort)
    );

    task automatic check(input string name, input word_t act, input word_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic word_t pack_obs(input logic [2:0] mk, input logic [71:0] d);
        word_t w;
        w            = '0;
        w[71:0]      = d;
        w[127:125]   = mk;
        return w;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Model: truncate/pad the received line to h pixels, then cut into words.
    task automatic model_line(input int h, input int npix, input bit first,
                              input bit last, input bit complete, input bit to_b);
        int    n, words, idx;
        word_t x;
        n     = (line_px.size() < h) ? line_px.size() : h;
        words = complete ? (h + npix - 1) / npix : n / npix;
        for (int w = 0; w < words; w++) begin
            x = '0;
            for (int k = 0; k < npix; k++) begin
                idx = w * npix + k;
                x[k*24 +: 24] = (idx < n) ? line_px[idx] : PAD;
            end
            x[127] = first && (w == 0);
            x[126] = complete && (w == words - 1);
            x[125] = x[126] && last;
            if (to_b) exp_b.push_back(x);
            else      exp_a.push_back(x);
        end
    endtask

    task automatic send_line(input int len, input int h, input int npix,
                             input bit first, input bit last, input bit complete,
                             input bit with_vs, input bit on_b, input int gap);
        line_px.delete();
        for (int i = 0; i < len; i++) line_px.push_back(24'($urandom));
        model_line(h, npix, first, last, complete, on_b);
        for (int i = 0; i < len; i++) begin
            de    = 1'b1;
            idata = line_px[i];
            if (with_vs && i == 0) begin
                if (on_b) vsync_b = 1'b1;
                else      vsync_a = 1'b1;
            end
            cyc();
            vsync_a = 1'b0;
            vsync_b = 1'b0;
        end
        de = 1'b0;
        repeat (gap) cyc();
    endtask

    task automatic send_frame(input int h, input int v, input bit overlap);
        hactive = 16'(h);
        vactive = 16'(v);
        if (!overlap) begin
            vsync_a = 1'b1;
            cyc();
            vsync_a = 1'b0;
            cyc();
        end
        for (int i = 0; i < v; i++) begin
            if (i < v - 1 && frame_lens[i] > h) exp_long  = 1'b1;
            if (frame_lens[i] < h)              exp_short = 1'b1;
            send_line(frame_lens[i], h, NPIX_A, i == 0, i == v - 1, 1'b1,
                      overlap && i == 0, 1'b0, h + 3);
        end
    endtask

    task automatic drive_raw(input int n);
        for (int i = 0; i < n; i++) begin
            de    = 1'b1;
            idata = 24'($urandom);
            cyc();
        end
        de = 1'b0;
        cyc();
    endtask

    task automatic clr_errs();
        err_clr = 1'b1;
        cyc();
        err_clr   = 1'b0;
        exp_long  = 1'b0;
        exp_short = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 64 && (exp_a.size() != 0 || exp_b.size() != 0); i++) cyc();
        check({name, "_drain_a"}, word_t'(exp_a.size()), '0);
        check({name, "_drain_b"}, word_t'(exp_b.size()), '0);
    endtask

    task automatic check_errs(input string name);
        check({name, "_err_long"},  word_t'(a_elong),  word_t'(exp_long));
        check({name, "_err_short"}, word_t'(a_eshort), word_t'(exp_short));
    endtask

    task automatic check_quiet(input string name);
        check({name, "_vld"},     word_t'({a_vld, b_vld}), '0);
        check({name, "_markers"}, word_t'({a_f, a_l, a_e, b_f, b_l, b_e}), '0);
        check({name, "_odata_a"}, word_t'(a_odata), '0);
        check({name, "_odata_b"}, word_t'(b_odata), '0);
        check({name, "_errs"},    word_t'({a_elong, a_eshort, b_elong, b_eshort}), '0);
    endtask

    always @(negedge clock) begin
        if (rst_n) begin
            if (a_vld) begin
                check("a_word_expected", word_t'(exp_a.size() != 0), word_t'(1));
                if (exp_a.size() != 0)
                    check("a_word", pack_obs({a_f, a_l, a_e}, 72'(a_odata)), exp_a.pop_front());
            end else begin
                check("a_markers_idle", word_t'({a_f, a_l, a_e}), '0);
            end
            if (b_vld) begin
                check("b_word_expected", word_t'(exp_b.size() != 0), word_t'(1));
                if (exp_b.size() != 0)
                    check("b_word", pack_obs({b_f, b_l, b_e}, b_odata), exp_b.pop_front());
            end else begin
                check("b_markers_idle", word_t'({b_f, b_l, b_e}), '0);
            end
        end
    end

    initial begin
        int h, v;
        bit ov;
        rst_n   = 1'b0;
        hactive = '0;
        vactive = '0;
        vsync_a = 1'b0;
        vsync_b = 1'b0;
        de      = 1'b0;
        idata   = '0;
        fsync   = 1'b0;
        err_clr = 1'b0;
        repeat (3) cyc();
        check_quiet("reset");
        rst_n = 1'b1;
        cyc();

        // Clean 4x2 frame: falign, lalign, -, lalign+ealign.
        clr_errs();
        frame_lens.delete(); frame_lens.push_back(4); frame_lens.push_back(4);
        send_frame(4, 2, 1'b0);
        drain("t1");
        check_errs("t1");

        // Odd hactive: last word is {PAD, px4}.
        clr_errs();
        frame_lens.delete(); frame_lens.push_back(5);
        send_frame(5, 1, 1'b0);
        drain("t2");
        check_errs("t2");

        // Short line padded to hactive.
        clr_errs();
        frame_lens.delete(); frame_lens.push_back(3);
        send_frame(6, 1, 1'b0);
        drain("t3");
        check_errs("t3");

        // Long line truncated, following line clean.
        clr_errs();
        frame_lens.delete(); frame_lens.push_back(8); frame_lens.push_back(6);
        send_frame(6, 2, 1'b0);
        drain("t4");
        check_errs("t4");

        // Frame-sync gating on the second instance: pixels before fsync ignored.
        hactive = 16'd4;
        vactive = 16'd1;
        vsync_b = 1'b1;
        cyc();
        vsync_b = 1'b0;
        cyc();
        drive_raw(4);
        fsync = 1'b1;
        cyc();
        fsync = 1'b0;
        send_line(4, 4, NPIX_B, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6);
        drain("t5");

        // Randomised frames, including hactive<=NPIX, vactive==1 and de on the vsync edge.
        for (int f = 0; f < 10; f++) begin
            clr_errs();
            h  = int'($urandom_range(7, 1));
            v  = int'($urandom_range(3, 1));
            ov = bit'($urandom_range(1, 0));
            frame_lens.delete();
            for (int i = 0; i < v; i++) frame_lens.push_back(int'($urandom_range(h + 2, 1)));
            send_frame(h, v, ov);
            drain("rand");
            check_errs("rand");
        end

        // Early vsync mid line 0 discards the partial word and restarts.
        clr_errs();
        hactive = 16'd4;
        vactive = 16'd2;
        vsync_a = 1'b1;
        cyc();
        vsync_a = 1'b0;
        cyc();
        send_line(3, 4, NPIX_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        frame_lens.delete(); frame_lens.push_back(4); frame_lens.push_back(4);
        send_frame(4, 2, 1'b1);
        exp_short = 1'b1;
        drain("t6");
        check_errs("t6");

        // Reset mid-frame: everything returns to 0 and the port stays idle.
        vsync_a = 1'b1;
        cyc();
        vsync_a = 1'b0;
        cyc();
        send_line(1, 4, NPIX_A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        rst_n = 1'b0;
        repeat (2) cyc();
        check_quiet("mid_reset");
        rst_n = 1'b1;
        cyc();
        drive_raw(5);
        drain("post_reset");
        check_quiet("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
